glm_store: RTL and testbench
============================

# glm_store

Writeback engine for the GLM pipeline: on `op_start` it streams a contiguous run of cache lines out of an on-chip region (model, gradient or result buffer) and writes them to DRAM through the DMA write channel. It sits beside the load engine in the instruction dispatcher, sharing the instruction register file and base address, and pulses `op_done` only after DRAM has acknowledged every written line.

## Interface
- `CLDATA_WIDTH`, 512: cache-line width in bits.
- `LOG2_MEMORY_SIZE`, 10: region address width in lines.
- `LOG2_STORE_FIFO`, 4: output staging FIFO depth, 16 lines.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `op_start` in 1: one-cycle start strobe; sampled only in IDLE.
- `op_done` out 1: one-cycle completion pulse.
- `regs` in 3x32: [0] DRAM line offset; [1][LOG2_MEMORY_SIZE-1:0] region start line; [2][30:0] length in lines.
- `in_addr` in `t_claddr`: DRAM base line address.
- `REGION_read.re / raddr` out 1 / LOG2_MEMORY_SIZE: region read request.
- `REGION_read.rvalid / rdata` in 1 / CLDATA_WIDTH: read response, in order, fixed latency ≤ 4 cycles.
- `DMA_write.control.start / addr / regs.reg4` out 1 / `t_claddr` / 32: job launch; reg4 = length.
- `DMA_write.status.idle / active` in 1 / 1.
- `DMA_write.tx_write.we / wdata` out 1 / CLDATA_WIDTH; `tx_write.almostfull` in 1.
- `DMA_write.rx_write.ack` in 1: one pulse per line committed to DRAM.

## Operation
- States: IDLE, DMA_TRIGGER, STREAM, WAIT_ACK, DONE.
- IDLE: on `op_start` latch `regs` and `in_addr`. The DRAM address is {in_addr upper bits, in_addr[31:0] + regs[0]}, and the 32-bit add wraps. Clear `num_read`, `num_sent` and `num_acked`. If the length is 0, go to DONE; otherwise go to DMA_TRIGGER.
- DMA_TRIGGER: wait for `status.idle`. Then pulse `control.start` with the address and reg4 = {1'b0, length}, and go to STREAM.
- STREAM, read side: issue `re` with `raddr` = start + `num_read` (mod 2^LOG2_MEMORY_SIZE) when three conditions hold: `status.active`, `num_read` < length, and `in_flight` + `fifo_count` < 2^LOG2_STORE_FIFO − 1. Here `in_flight` = `num_read` − lines written into the FIFO.
- STREAM, write side: every `rvalid` pushes `rdata` into the FIFO. Pop when the FIFO is non-empty and `almostfull` is low, then drive `tx_write.we`/`wdata` and increment `num_sent`. Go to WAIT_ACK when `num_sent` reaches length.
- WAIT_ACK: count `ack` pulses, which are also counted during STREAM. When `num_acked` == length, go to DONE.
- DONE: pulse `op_done` for one cycle and return to IDLE.
- `op_start` outside IDLE is ignored.
- Counters are 32-bit unsigned; length bit 31 is ignored.
- An `ack` in excess of length is ignored. A `rvalid` with nothing outstanding is dropped.

## Timing
- Reset values: `op_done`, `re`, `control.start` and `tx_write.we` are 0. `raddr`, `control.addr`, `reg4` and `wdata` are 0. State is IDLE and the FIFO is empty.
- Reset asserted mid-operation aborts immediately: no pulse completes and there is no `op_done`.
- All outputs are registered.
- `op_start` to `control.start`: 2 cycles when `status.idle` is already high.
- `rvalid` to `tx_write.we`: 2 cycles (FIFO write, then registered pop) when `almostfull` is low.
- Steady state: one line per cycle with no bubbles while `almostfull` is low.
- `almostfull` stops pops the cycle after it is sampled high. Reads stall only through the credit check, so the FIFO never overflows.
- `ack` may arrive in the same cycle as `tx_write.we`. `ack` and `rvalid` may coincide, and both are counted.
- `op_done` is asserted 1 cycle after the final ack is sampled.
- Zero length: `op_done` 2 cycles after `op_start`; no DMA or region traffic.

## Structure
- `t_claddr`, `CLDATA_WIDTH`, `LOG2_MEMORY_SIZE` and the state enum belong in the GLM common package. Reuse the existing DMA-write and fifobram interfaces.
- The sub-module is `glm_store_fifo`: show-ahead, `count` output, parameterised on width and depth. Credit logic stays in the top.

## Test plan
- Length 5, offset 0x100, region start 0, DMA always idle and ready: 5 reads at raddr 0..4, DMA addr = base + 0x100, 5 writes with matching data, `op_done` 1 cycle after the 5th ack.
- Length 0: no `control.start`, no `re`, `op_done` at cycle +2.
- Length 64, `almostfull` toggled 8 on / 8 off: no data loss or reordering, `fifo_count` never above 15, all 64 lines written in order.
- Region start 1022, length 4, LOG2_MEMORY_SIZE 10: raddr sequence 1022, 1023, 0, 1.
- `status.idle` held low for 20 cycles after start: `control.start` issued exactly once, in the cycle after idle rises. `op_start` pulsed mid-job is ignored.
- Reset asserted during STREAM after 7 of 32 lines: all outputs 0 in the same cycle, and no `op_done`. A new job of length 3 then completes normally.

Source files
------------

// File: rtl/glm_store_pkg.sv
// Shared types and constants for the GLM writeback engine.
package glm_store_pkg;

  localparam int unsigned CLDATA_WIDTH     = 512;
  localparam int unsigned LOG2_MEMORY_SIZE = 10;
  localparam int unsigned LOG2_STORE_FIFO  = 4;
  localparam int unsigned STORE_FIFO_DEPTH = 1 << LOG2_STORE_FIFO;
  localparam int unsigned CLADDR_WIDTH     = 42;

  typedef logic [CLADDR_WIDTH-1:0] t_claddr;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DMA_TRIGGER,
    ST_STREAM,
    ST_WAIT_ACK,
    ST_DONE
  } t_store_state;

  // DRAM line address: the low 32 bits take the offset with wrap-around,
  // the upper bits of the base pass through untouched.
  function automatic t_claddr dram_line_addr(input t_claddr base, input logic [31:0] offset);
    return {base[CLADDR_WIDTH-1:32], base[31:0] + offset};
  endfunction

endpackage

// File: rtl/glm_store_fifo.sv
// Show-ahead staging FIFO: rdata always presents the oldest entry.
// Push when full and pop when empty are ignored.
module glm_store_fifo #(
  parameter int unsigned WIDTH      = 512,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/glm_store.sv
// GLM writeback engine: streams a run of region lines out to DRAM through
// the DMA write channel and pulses op_done once every line is acknowledged.
//
// Handshakes: op_start, region_re, dma_start, tx_we, region_rvalid and
// rx_ack are single-cycle strobes with no ready return. Flow control is
// by credit on the read side (lines requested but not yet staged plus
// FIFO occupancy stay below depth-1) and by tx_almostfull on the write
// side, which blocks the pop at the edge it is sampled high.
module glm_store
  import glm_store_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        op_start,
  output logic                        op_done,
  input  logic [2:0][31:0]            regs,
  input  t_claddr                     in_addr,
  output logic                        region_re,
  output logic [LOG2_MEMORY_SIZE-1:0] region_raddr,
  input  logic                        region_rvalid,
  input  logic [CLDATA_WIDTH-1:0]     region_rdata,
  output logic                        dma_start,
  output t_claddr                     dma_addr,
  output logic [31:0]                 dma_reg4,
  input  logic                        dma_idle,
  input  logic                        dma_active,
  output logic                        tx_we,
  output logic [CLDATA_WIDTH-1:0]     tx_wdata,
  input  logic                        tx_almostfull,
  input  logic                        rx_ack,
  output t_store_state                state,
  output logic [LOG2_STORE_FIFO:0]    fifo_count
);

  logic [30:0]                 len_q;
  logic [LOG2_MEMORY_SIZE-1:0] start_line_q;
  t_claddr                     dram_addr_q;
  logic [31:0]                 num_read;
  logic [31:0]                 num_written;
  logic [31:0]                 num_sent;
  logic [31:0]                 num_acked;

  logic [31:0]                 len32;
  logic [31:0]                 in_flight;
  logic [31:0]                 sent_next;
  logic [31:0]                 acked_next;
  logic                        credit_ok;
  logic                        can_read;
  logic                        can_pop;
  logic                        ack_take;
  logic                        fifo_push;
  logic                        fifo_empty;
  logic [CLDATA_WIDTH-1:0]     fifo_rdata;
  logic                        unused_bits;

  assign unused_bits = ^{regs[1][31:LOG2_MEMORY_SIZE], regs[2][31]};

  assign len32     = {1'b0, len_q};
  assign in_flight = num_read - num_written;
  // A response with nothing outstanding is dropped rather than staged.
  assign fifo_push = region_rvalid && (in_flight != '0);
  assign credit_ok = (in_flight + 32'(fifo_count)) < 32'(STORE_FIFO_DEPTH - 1);
  assign can_read  = (state == ST_STREAM) && dma_active && (num_read < len32) && credit_ok;
  assign can_pop   = (state == ST_STREAM) && !fifo_empty && !tx_almostfull && (num_sent < len32);
  assign ack_take  = rx_ack && (num_acked < len32) &&
                     ((state == ST_STREAM) || (state == ST_WAIT_ACK));
  assign sent_next  = num_sent + 32'(can_pop);
  assign acked_next = num_acked + 32'(ack_take);

  glm_store_fifo #(
    .WIDTH      (CLDATA_WIDTH),
    .DEPTH_LOG2 (LOG2_STORE_FIFO)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (region_rdata),
    .pop   (can_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Control FSM with registered strobes, addresses, data and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_done      <= 1'b0;
      region_re    <= 1'b0;
      region_raddr <= '0;
      dma_start    <= 1'b0;
      dma_addr     <= '0;
      dma_reg4     <= '0;
      tx_we        <= 1'b0;
      tx_wdata     <= '0;
      len_q        <= '0;
      start_line_q <= '0;
      dram_addr_q  <= '0;
      num_read     <= '0;
      num_written  <= '0;
      num_sent     <= '0;
      num_acked    <= '0;
    end else begin
      op_done   <= 1'b0;
      region_re <= 1'b0;
      dma_start <= 1'b0;
      tx_we     <= 1'b0;
      if (fifo_push) num_written <= num_written + 32'd1;

      case (state)
        ST_IDLE: begin
          if (op_start) begin
            len_q        <= regs[2][30:0];
            start_line_q <= regs[1][LOG2_MEMORY_SIZE-1:0];
            dram_addr_q  <= dram_line_addr(in_addr, regs[0]);
            num_read     <= '0;
            num_written  <= '0;
            num_sent     <= '0;
            num_acked    <= '0;
            state        <= (regs[2][30:0] == '0) ? ST_DONE : ST_DMA_TRIGGER;
          end
        end

        ST_DMA_TRIGGER: begin
          if (dma_idle) begin
            dma_start <= 1'b1;
            dma_addr  <= dram_addr_q;
            dma_reg4  <= len32;
            state     <= ST_STREAM;
          end
        end

        ST_STREAM: begin
          if (can_read) begin
            region_re    <= 1'b1;
            region_raddr <= start_line_q + num_read[LOG2_MEMORY_SIZE-1:0];
            num_read     <= num_read + 32'd1;
          end
          if (can_pop) begin
            tx_we    <= 1'b1;
            tx_wdata <= fifo_rdata;
          end
          num_sent  <= sent_next;
          num_acked <= acked_next;
          if (sent_next == len32) begin
            if (acked_next == len32) begin
              op_done <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_WAIT_ACK;
            end
          end
        end

        ST_WAIT_ACK: begin
          num_acked <= acked_next;
          if (acked_next == len32) begin
            op_done <= 1'b1;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          // The ack path raises op_done on entry so it lands one cycle after
          // the final ack; a zero-length job arrives here with it low and
          // raises it now instead.
          op_done <= !op_done;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glm_store.sv
// Directed bench for glm_store: region memory and DMA responders, an
// in-order scoreboard for read addresses and written data, and a linear
// sequence of jobs with hand-computed expectations.
module tb_glm_store;
  import glm_store_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        op_start;
  logic                        op_done;
  logic [2:0][31:0]            regs;
  t_claddr                     in_addr;
  logic                        region_re;
  logic [LOG2_MEMORY_SIZE-1:0] region_raddr;
  logic                        region_rvalid;
  logic [CLDATA_WIDTH-1:0]     region_rdata;
  logic                        dma_start;
  t_claddr                     dma_addr;
  logic [31:0]                 dma_reg4;
  logic                        dma_idle;
  logic                        dma_active;
  logic                        tx_we;
  logic [CLDATA_WIDTH-1:0]     tx_wdata;
  logic                        tx_almostfull;
  logic                        rx_ack;
  t_store_state                state;
  logic [LOG2_STORE_FIFO:0]    fifo_count;

  glm_store dut (
    .clk           (clk),
    .reset         (reset),
    .op_start      (op_start),
    .op_done       (op_done),
    .regs          (regs),
    .in_addr       (in_addr),
    .region_re     (region_re),
    .region_raddr  (region_raddr),
    .region_rvalid (region_rvalid),
    .region_rdata  (region_rdata),
    .dma_start     (dma_start),
    .dma_addr      (dma_addr),
    .dma_reg4      (dma_reg4),
    .dma_idle      (dma_idle),
    .dma_active    (dma_active),
    .tx_we         (tx_we),
    .tx_wdata      (tx_wdata),
    .tx_almostfull (tx_almostfull),
    .rx_ack        (rx_ack),
    .state         (state),
    .fifo_count    (fifo_count)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [CLDATA_WIDTH-1:0]     exp_q[$];
  logic [LOG2_MEMORY_SIZE-1:0] exp_raddr_q[$];
  logic [CLDATA_WIDTH-1:0]     exp_d;
  logic [LOG2_MEMORY_SIZE-1:0] exp_a;

  logic [31:0] salt = 32'h0;
  int n_re, n_we, n_ack, n_done, n_start;
  int unsigned start_cyc, dma_start_cyc, ack_cyc, done_cyc, idle_cyc;
  t_claddr     dma_addr_seen;
  logic [31:0] dma_reg4_seen;
  int          max_fc;
  logic        af_mode = 1'b0;
  logic        af_prev;

  logic [2:0]                  rv_pipe = '0;
  logic [LOG2_MEMORY_SIZE-1:0] ra_pipe [3];
  logic [2:0]                  ack_pipe = '0;

  task automatic check(input string tag, input logic [CLDATA_WIDTH-1:0] obs,
                       input logic [CLDATA_WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CLDATA_WIDTH-1:0] mkdata(input logic [LOG2_MEMORY_SIZE-1:0] a);
    logic [CLDATA_WIDTH-1:0] d;
    for (int w = 0; w < CLDATA_WIDTH / 32; w++)
      d[w*32 +: 32] = salt ^ ({22'd0, a} << 8) ^ 32'(w);
    return d;
  endfunction

  // ---------------- responders and scoreboard (negedge) ----------------
  always @(negedge clk) begin
    if (reset) begin
      rv_pipe       = '0;
      ack_pipe      = '0;
      region_rvalid = 1'b0;
      rx_ack        = 1'b0;
      tx_almostfull = 1'b0;
    end else begin
      // Region memory: fixed two-stage response latency.
      region_rvalid = rv_pipe[1];
      region_rdata  = mkdata(ra_pipe[1]);
      rv_pipe[1]    = rv_pipe[0];
      ra_pipe[1]    = ra_pipe[0];
      rv_pipe[0]    = region_re;
      ra_pipe[0]    = region_raddr;
      if (region_re) begin
        n_re++;
        if (exp_raddr_q.size() != 0) begin
          exp_a = exp_raddr_q.pop_front();
          check("raddr", region_raddr, exp_a);
        end
      end

      // DMA write channel: ack each line two cycles after it is written.
      rx_ack = ack_pipe[1];
      if (ack_pipe[1]) begin
        n_ack++;
        ack_cyc = cyc;
      end
      ack_pipe[1] = ack_pipe[0];
      ack_pipe[0] = tx_we;

      af_prev = tx_almostfull;
      if (tx_we) begin
        n_we++;
        check("af_stall", af_prev, 1'b0);
        if (exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          check("wdata", tx_wdata, exp_d);
        end
      end
      tx_almostfull = af_mode ? (((cyc / 8) % 2) == 1) : 1'b0;

      if (dma_start) begin
        n_start++;
        dma_start_cyc = cyc;
        dma_addr_seen = dma_addr;
        dma_reg4_seen = dma_reg4;
      end
      if (op_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (int'(fifo_count) > max_fc) max_fc = int'(fifo_count);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    n_re = 0; n_we = 0; n_ack = 0; n_done = 0; n_start = 0; max_fc = 0;
  endtask

  task automatic start_job(input logic [31:0] offset, input logic [31:0] start_line,
                           input logic [31:0] len, input logic [31:0] s);
    logic [LOG2_MEMORY_SIZE-1:0] la;
    salt = s;
    exp_q.delete();
    exp_raddr_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      la = LOG2_MEMORY_SIZE'(start_line + 32'(i));
      exp_raddr_q.push_back(la);
      exp_q.push_back(mkdata(la));
    end
    clear_stats();
    @(negedge clk);
    regs[0]   = offset;
    regs[1]   = start_line;
    regs[2]   = len;
    op_start  = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n_done == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", n_done != 0, 1'b1);
    repeat (6) @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset         = 1'b1;
    op_start      = 1'b0;
    regs          = '0;
    in_addr       = '0;
    dma_idle      = 1'b1;
    dma_active    = 1'b1;
    region_rvalid = 1'b0;
    region_rdata  = '0;
    tx_almostfull = 1'b0;
    rx_ack        = 1'b0;
    clear_stats();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check("rst_state", state, ST_IDLE);
    check("rst_op_done", op_done, 1'b0);
    check("rst_re", region_re, 1'b0);
    check("rst_raddr", region_raddr, '0);
    check("rst_start", dma_start, 1'b0);
    check("rst_addr", dma_addr, '0);
    check("rst_reg4", dma_reg4, '0);
    check("rst_we", tx_we, 1'b0);
    check("rst_wdata", tx_wdata, '0);
    check("rst_fifo", fifo_count, '0);

    // Job 1: length 5, offset 0x100, region start 0.
    in_addr = {10'h155, 32'h1000_0000};
    start_job(32'h100, 32'd0, 32'd5, 32'hA5A5_0001);
    wait_done(200);
    check("j1_re_count", n_re, 5);
    check("j1_we_count", n_we, 5);
    check("j1_ack_count", n_ack, 5);
    check("j1_start_count", n_start, 1);
    check("j1_done_count", n_done, 1);
    check("j1_dma_addr", dma_addr_seen, {10'h155, 32'h1000_0100});
    check("j1_reg4", dma_reg4_seen, 32'd5);
    check("j1_start_lat", dma_start_cyc - start_cyc, 2);
    check("j1_done_lat", done_cyc - ack_cyc, 1);
    check("j1_exp_left", exp_q.size(), 0);
    check("j1_state", state, ST_IDLE);

    // Job 2: zero length.
    start_job(32'h0, 32'd7, 32'd0, 32'h0);
    wait_done(20);
    check("j2_start_count", n_start, 0);
    check("j2_re_count", n_re, 0);
    check("j2_we_count", n_we, 0);
    check("j2_done_count", n_done, 1);
    check("j2_done_lat", done_cyc - start_cyc, 2);

    // Job 3: length 64 with almostfull toggling 8 on / 8 off.
    af_mode = 1'b1;
    start_job(32'h20, 32'd300, 32'd64, 32'h0BAD_F00D);
    wait_done(3000);
    af_mode = 1'b0;
    check("j3_we_count", n_we, 64);
    check("j3_re_count", n_re, 64);
    check("j3_ack_count", n_ack, 64);
    check("j3_fifo_max", max_fc > 15, 1'b0);
    check("j3_exp_left", exp_q.size(), 0);
    check("j3_reg4", dma_reg4_seen, 32'd64);

    // Job 4: region wrap 1022..1, DRAM offset wraps the low 32 bits.
    in_addr = {10'h2AB, 32'hFFFF_FF80};
    start_job(32'h100, 32'd1022, 32'd4, 32'h1234_5678);
    wait_done(200);
    check("j4_re_count", n_re, 4);
    check("j4_we_count", n_we, 4);
    check("j4_raddr_left", exp_raddr_q.size(), 0);
    check("j4_dma_addr", dma_addr_seen, {10'h2AB, 32'h0000_0080});

    // Job 5: DMA busy for 20 cycles, stray op_start mid-job.
    dma_idle = 1'b0;
    start_job(32'h0, 32'd50, 32'd12, 32'h5555_AAAA);
    repeat (20) @(negedge clk);
    check("j5_no_early_start", n_start, 0);
    dma_idle = 1'b1;
    idle_cyc = cyc;
    repeat (6) @(negedge clk);
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    wait_done(300);
    repeat (10) @(negedge clk);
    check("j5_start_count", n_start, 1);
    check("j5_start_cyc", dma_start_cyc - idle_cyc, 1);
    check("j5_done_count", n_done, 1);
    check("j5_we_count", n_we, 12);
    check("j5_state", state, ST_IDLE);

    // Job 6: reset during STREAM after 7 of 32 lines.
    start_job(32'h40, 32'd100, 32'd32, 32'hCAFE_0006);
    begin
      int n = 0;
      while (n_we < 7 && n < 500) begin
        @(posedge clk);
        #2;
        n++;
      end
      check("j6_reach7_timeout", n_we >= 7, 1'b1);
    end
    reset = 1'b1;
    #1;
    check("j6_rst_re", region_re, 1'b0);
    check("j6_rst_raddr", region_raddr, '0);
    check("j6_rst_start", dma_start, 1'b0);
    check("j6_rst_addr", dma_addr, '0);
    check("j6_rst_reg4", dma_reg4, '0);
    check("j6_rst_we", tx_we, 1'b0);
    check("j6_rst_wdata", tx_wdata, '0);
    check("j6_rst_done", op_done, 1'b0);
    check("j6_rst_state", state, ST_IDLE);
    check("j6_rst_fifo", fifo_count, '0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    exp_raddr_q.delete();
    clear_stats();
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("j6_no_done", n_done, 0);
    check("j6_no_we", n_we, 0);

    // Job 7: fresh length-3 job after the abort.
    start_job(32'h8, 32'd200, 32'd3, 32'h7777_0007);
    wait_done(200);
    check("j7_we_count", n_we, 3);
    check("j7_done_count", n_done, 1);
    check("j7_done_lat", done_cyc - ack_cyc, 1);
    check("j7_exp_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
